// File: rtl/axist_csr_responder.sv
// Avalon-MM CSR responder for the AXI-Stream-over-AIB test harness: decodes the
// BASE_ADDR register window and drives delay, AXI-reset and packet-generator controls.
module axist_csr_responder #(
    parameter logic [31:0] BASE_ADDR      = 32'h5000_0000,
    parameter logic [31:0] UNMAPPED_RDATA = 32'h0000_0000
) (
    input  logic        mgmt_clk,
    input  logic        rst,
    input  logic [31:0] i_address,
    input  logic        i_write,
    input  logic        i_read,
    input  logic [31:0] i_writedata,
    output logic [31:0] o_readdata,
    output logic        o_readdatavalid,
    output logic        o_waitrequest,
    input  logic [3:0]  i_linkup,
    input  logic [3:0]  i_ckr_sts,
    input  logic [63:0] i_dout_first,
    input  logic [63:0] i_dout_last,
    input  logic [63:0] i_din_first,
    input  logic [63:0] i_din_last,
    output logic [7:0]  o_delay_x,
    output logic [7:0]  o_delay_y,
    output logic [15:0] o_delay_z,
    output logic        o_axi_rst,
    output logic        o_tx_start,
    output logic [2:0]  o_tx_mode,
    output logic [7:0]  o_tx_pkt_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESP    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] addr_q;
    logic [15:0] wdata_q;
    logic        is_write;
    logic        is_read;

    logic        base_hit;
    logic [15:0] offset;
    logic        cap_hit;
    logic [1:0]  cap_idx;
    logic        cap_hi;
    logic [63:0] cap_src [4];
    logic [31:0] shadow  [4];
    logic [31:0] rd_mux;

    logic        commit;
    logic        read_done;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge mgmt_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_write || i_read) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = RELEASE;
            RELEASE: if (!i_write && !i_read) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Write has priority when both strobes are high; the read is simply dropped.
    always_ff @(posedge mgmt_clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            is_write <= 1'b0;
            is_read  <= 1'b0;
        end else if (state == IDLE && (i_write || i_read)) begin
            addr_q   <= i_address;
            wdata_q  <= i_writedata[15:0];
            is_write <= i_write;
            is_read  <= !i_write;
        end
    end

    always_comb begin
        base_hit   = (addr_q[31:16] == BASE_ADDR[31:16]);
        offset     = addr_q[15:0];
        cap_hit    = base_hit && (offset[15:10] == 6'b010000) && (offset[7:3] == 5'd0)
                     && (offset[1:0] == 2'd0);
        cap_idx    = offset[9:8];
        cap_hi     = offset[2];
        cap_src[0] = i_dout_first;
        cap_src[1] = i_dout_last;
        cap_src[2] = i_din_first;
        cap_src[3] = i_din_last;
        commit     = (state == ACCESS) && is_write && base_hit;
        read_done  = (state == ACCESS) && is_read;
    end

    always_comb begin
        rd_mux = UNMAPPED_RDATA;
        if (cap_hit) begin
            rd_mux = cap_hi ? shadow[cap_idx] : cap_src[cap_idx][31:0];
        end else if (base_hit) begin
            case (offset)
                16'h1000: rd_mux = {20'd0, o_tx_pkt_cnt, o_tx_mode, 1'b0};
                16'h1004: rd_mux = {28'd0, i_ckr_sts};
                16'h1008: rd_mux = {28'd0, i_linkup};
                16'h2000: rd_mux = {24'd0, o_delay_x};
                16'h2004: rd_mux = {24'd0, o_delay_y};
                16'h2008: rd_mux = {16'd0, o_delay_z};
                16'h3000: rd_mux = {31'd0, o_axi_rst};
                default:  rd_mux = UNMAPPED_RDATA;
            endcase
        end
    end

    // Writes commit on the edge into RESP so new values and the start pulse show up during RESP.
    always_ff @(posedge mgmt_clk or posedge rst) begin
        if (rst) begin
            o_delay_x    <= '0;
            o_delay_y    <= '0;
            o_delay_z    <= '0;
            o_axi_rst    <= 1'b0;
            o_tx_start   <= 1'b0;
            o_tx_mode    <= '0;
            o_tx_pkt_cnt <= '0;
        end else begin
            o_tx_start <= 1'b0;
            if (commit) begin
                case (offset)
                    16'h1000: begin
                        o_tx_start   <= wdata_q[0];
                        o_tx_mode    <= wdata_q[3:1];
                        o_tx_pkt_cnt <= wdata_q[11:4];
                    end
                    16'h2000: o_delay_x <= wdata_q[7:0];
                    16'h2004: o_delay_y <= wdata_q[7:0];
                    16'h2008: o_delay_z <= wdata_q;
                    16'h3000: o_axi_rst <= wdata_q[0];
                    default:  ;
                endcase
            end
        end
    end

    // NOTE: the shadow words are few and must read 0 before any low-word read, so they are reset.
    always_ff @(posedge mgmt_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) shadow[i] <= '0;
        end else if (read_done && cap_hit && !cap_hi) begin
            shadow[cap_idx] <= cap_src[cap_idx][63:32];
        end
    end

    // Response flops: waitrequest drops and readdatavalid rises only for the RESP cycle.
    always_ff @(posedge mgmt_clk or posedge rst) begin
        if (rst) begin
            o_waitrequest   <= 1'b1;
            o_readdatavalid <= 1'b0;
            o_readdata      <= '0;
        end else begin
            o_waitrequest   <= (state != ACCESS);
            o_readdatavalid <= read_done;
            if (read_done) o_readdata <= rd_mux;
        end
    end

endmodule

// File: doc/axist_csr_responder.md
# axist_csr_responder

Memory-mapped CSR responder for the AXI-Stream-over-AIB test harness. It sits on the management Avalon-MM bus opposite the harness master, decodes the 0x5000_xxxx register map, and returns read data with a `o_readdatavalid`/`o_waitrequest` handshake. It drives the delay, AXI-reset and packet-generator controls, and exposes link, checker and captured-data status.

## Interface
Parameters:
- `BASE_ADDR`, 32'h5000_0000: upper address match; bits [31:16] must equal `BASE_ADDR[31:16]`.
- `UNMAPPED_RDATA`, 32'h0000_0000: read data returned for unmapped addresses.

Ports:
- `mgmt_clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `i_address` in 32: byte address, word aligned.
- `i_write` in 1: write request, level, held until `o_waitrequest` is low.
- `i_read` in 1: read request, level, held until `o_waitrequest` is low.
- `i_writedata` in 32: write data.
- `o_readdata` out 32: read data, valid with `o_readdatavalid`.
- `o_readdatavalid` out 1: one-cycle read response strobe.
- `o_waitrequest` out 1: stall; low for exactly one cycle per accepted access.
- `i_linkup` in 4: {rx_online, tx_online, sl_align_done, ms_align_done}.
- `i_ckr_sts` in 4: [0] pass, [1] done, [2] reserved, [3] align_done.
- `i_dout_first`, `i_dout_last`, `i_din_first`, `i_din_last` in 64 each: captured data words.
- `o_delay_x` out 8, `o_delay_y` out 8, `o_delay_z` out 16: delay values.
- `o_axi_rst` out 1: AXI interface soft reset.
- `o_tx_start` out 1: one-cycle packet-generator start pulse.
- `o_tx_mode` out 3: pattern mode.
- `o_tx_pkt_cnt` out 8: packet count minus 1.

## Operation
Register map (offset from `BASE_ADDR`):
- 0x1000 TX_PKT_CTRL, RW: [0] start (write-1 pulse, reads 0), [3:1] mode, [11:4] pkt_cnt.
- 0x1004 RX_CKR_STS, RO: `{28'b0, i_ckr_sts}`.
- 0x1008 LINKUP_STS, RO: `{28'b0, i_linkup}`.
- 0x2000, 0x2004, 0x2008, RW: delay X [7:0], Y [7:0], Z [15:0]; upper bits read 0.
- 0x3000 AXI_CTRL, RW: [0] `o_axi_rst`.
- 0x4000/0x4004, 0x4100/0x4104, 0x4200/0x4204, 0x4300/0x4304, RO: DOUT_FIRST, DOUT_LAST, DIN_FIRST, DIN_LAST. The +0 word returns bits [31:0]; the +4 word returns bits [63:32].
  - Reading a +0 word snapshots bits [63:32] of that source into a per-source shadow register.
  - The +4 read returns the shadow, so a lo-then-hi pair is coherent.
  - A +4 read with no prior +0 read returns the shadow's reset value, 0.

Any other address, or a base mismatch, is unmapped: reads return `UNMAPPED_RDATA`, writes are dropped, and the handshake still completes.

State machine `IDLE → ACCESS → RESP → RELEASE → IDLE`:
- `IDLE`: on `i_write` or `i_read`, latch address and data, then go to `ACCESS`. If both are high, the write wins and the read is dropped, with no `o_readdatavalid`.
- `ACCESS`: register decode and read mux, then go to `RESP`.
- `RESP`: `o_waitrequest`=0 for one cycle.
  - Write: commit the register; `o_tx_start` pulses this cycle if bit 0 = 1.
  - Read: `o_readdatavalid`=1 with `o_readdata`.
  - Next state is `RELEASE`.
- `RELEASE`: `o_waitrequest`=1; wait until `i_read` and `i_write` are both 0, then go to `IDLE`. This stops a held level request from being accepted twice.

Reset values:
- All RW fields 0, so `o_axi_rst`=0, `o_tx_start`=0, `o_tx_mode`=0 and `o_tx_pkt_cnt`=0.
- `o_waitrequest`=1, `o_readdatavalid`=0, `o_readdata`=0.
- Shadow registers 0; state `IDLE`.

## Timing
- Request sampled high in `IDLE` at cycle N: response at cycle N+2, where `o_waitrequest`=0 and (for reads) `o_readdatavalid`=1 in the same cycle.
- `o_readdata` holds its value until the next read response; it is not cleared.
- Status inputs are sampled in `ACCESS` at cycle N+1. Inputs must be stable or already synchronous to `mgmt_clk`; this block does no synchronization.
- RW outputs change on the `RESP` edge and are registered; `o_tx_start` is exactly one cycle wide.
- Minimum back-to-back spacing: 4 cycles (IDLE, ACCESS, RESP, RELEASE with the request dropped).
- `rst` mid-access: returns to `IDLE` asynchronously, no response is issued, and all outputs go to reset values.

## Test plan
- After reset, read 0x5000_2008 → `o_readdatavalid` at N+2 with data 0; `o_waitrequest` low for exactly one cycle.
- Write 0x5000_2000=0x0C, 0x5000_2004=0x20, 0x5000_2008=0x1770, then read each back → 0x0C, 0x20, 0x1770; `o_delay_*` match.
- Write 0x5000_1000=0xFF5 → `o_tx_start` one-cycle pulse, `o_tx_mode`=3'b010, `o_tx_pkt_cnt`=0xFF; readback = 0xFF4.
- Set `i_dout_first`=0x1111_2222_3333_4444, read 0x5000_4000, change input to 0xAAAA_BBBB_CCCC_DDDD, read 0x5000_4004 → 0x3333_4444 then 0x1111_2222.
- Hold `i_read` high for 10 cycles at 0x5000_1008 with `i_linkup`=4'hF → exactly one `o_readdatavalid` with data 0xF. Read 0x5000_9000 → 0x0, handshake completes.
- Assert `rst` during `ACCESS` of a write to 0x5000_3000 with data 1 → no response, `o_axi_rst` stays 0, `o_waitrequest`=1; the next read works normally.
